mem_access: RTL and testbench

Memory-access stage of the five-stage pipeline: consumes the EX/MEM register outputs, performs data-memory loads and stores against a local word-addressed RAM, resolves branch taken/target, and drives the MEM/WB pipeline register toward write-back. Loads take a parameterized number of cycles, so the stage raises a stall to freeze upstream stages while a load is in flight.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/data_memory.sv | 22 ++
 rtl/mem_access.sv | 134 +++++++++++++
 tb/tb_mem_access.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types shared by the memory-access and write-back stages: FSM states,
// register/jump field widths and the MEM/WB bundle.
package pipeline_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int JUMP_ADDR_W = 11;
  localparam int XLEN        = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]       read_data;
    logic [XLEN-1:0]       alu_result;
    logic [REG_ADDR_W-1:0] reg_dest;
    logic                  mem_to_reg;
    logic                  reg_write;
  } mem_wb_t;

  // A misaligned memory op, or one asking to read and write at once, is refused.
  function automatic logic is_illegal(input logic [1:0] byte_off,
                                      input logic rd, input logic wr);
    return ((byte_off != 2'b00) && (rd || wr)) || (rd && wr);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous word RAM with registered read data.
// Read-during-write returns the old word; contents survive reset.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (write_en) mem[addr] <= write_data;
    if (read_en)  read_data <= mem[addr];
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: loads/stores against local RAM, branch resolve, MEM/WB register.
// Multi-cycle loads raise stall_out and feed bubbles into MEM/WB until data returns.
module mem_access
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  result_in,
  input  logic [DATA_WIDTH-1:0]  registro_2_in,
  input  logic [REG_ADDR_W-1:0]  reg_dest_in,
  input  logic [JUMP_ADDR_W-1:0] jump_dest_addr_in,
  input  logic                   zero_signal_in,
  input  logic                   MemToReg_in,
  input  logic                   RegWrite_in,
  input  logic                   MemRead_in,
  input  logic                   MemWrite_in,
  input  logic                   Branch_in,
  output logic [DATA_WIDTH-1:0]  read_data_out,
  output logic [DATA_WIDTH-1:0]  alu_result_out,
  output logic [REG_ADDR_W-1:0]  reg_dest_out,
  output logic                   MemToReg_out,
  output logic                   RegWrite_out,
  output logic                   pc_src_out,
  output logic [JUMP_ADDR_W-1:0] branch_target_out,
  output logic                   stall_out,
  output logic                   addr_error_out
);

  localparam logic [3:0] LOAD_CNT  = 4'(MEM_LATENCY - 1);
  localparam logic       MULTI_CYC = (MEM_LATENCY > 1);

  mem_state_t            state;
  logic [3:0]            cnt;
  logic                  err;
  mem_wb_t               mw_q;
  logic                  load_q;
  mem_wb_t               entry;
  logic [ADDR_BITS-1:0]  word_idx;
  logic                  illegal;
  logic                  in_idle;
  logic                  load_start;
  logic                  load_finish;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign word_idx    = result_in[ADDR_BITS+1:2];
  assign illegal     = is_illegal(result_in[1:0], MemRead_in, MemWrite_in);
  assign in_idle     = (state == IDLE);
  assign load_start  = in_idle & MemRead_in & ~illegal;
  assign load_finish = (load_start & ~MULTI_CYC) | ((state == WAIT) & (cnt == 4'd1));

  // Stores only issue from IDLE; loads read on the edge that completes them.
  assign ram_we = ~reset & in_idle & MemWrite_in & ~illegal;
  assign ram_re = ~reset & load_finish;

  assign stall_out = ~reset & ((load_start & MULTI_CYC) | ((state == WAIT) & (cnt > 4'd1)));

  data_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem (
    .clock     (clock),
    .write_en  (ram_we),
    .addr      (word_idx),
    .write_data(registro_2_in),
    .read_en   (ram_re),
    .read_data (ram_rdata)
  );

  always_comb begin
    entry            = '0;
    entry.alu_result = result_in;
    entry.reg_dest   = reg_dest_in;
    entry.mem_to_reg = MemToReg_in;
    entry.reg_write  = RegWrite_in & ~illegal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err    <= 1'b0;
      mw_q   <= '0;
      load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (illegal) begin
            err    <= 1'b1;
            mw_q   <= entry;
            load_q <= 1'b0;
          end else if (load_start && MULTI_CYC) begin
            state  <= WAIT;
            cnt    <= LOAD_CNT;
            mw_q   <= '0;
            load_q <= 1'b0;
          end else begin
            mw_q   <= entry;
            load_q <= MemRead_in;
          end
        end
        WAIT: begin
          if (cnt > 4'd1) begin
            cnt    <= cnt - 4'd1;
            mw_q   <= '0;
            load_q <= 1'b0;
          end else begin
            state  <= IDLE;
            cnt    <= 4'd0;
            mw_q   <= entry;
            load_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load data comes straight from the RAM's output register, aligned with MEM/WB.
  assign read_data_out     = load_q ? ram_rdata : mw_q.read_data;
  assign alu_result_out    = mw_q.alu_result;
  assign reg_dest_out      = mw_q.reg_dest;
  assign MemToReg_out      = mw_q.mem_to_reg;
  assign RegWrite_out      = mw_q.reg_write;
  assign addr_error_out    = err;
  assign pc_src_out        = Branch_in & zero_signal_in;
  assign branch_target_out = jump_dest_addr_in;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench: two DUTs (load latency 2 and 4) share stimulus; one is checked per phase.
module tb_mem_access;

  localparam int K_FULL = 0;
  localparam int K_BUB  = 1;
  localparam int K_ILL  = 2;

  typedef struct {
    logic        stall;
    logic        pc;
    logic [10:0] tgt;
    int          kind;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        m2r;
    logic        rw;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] result_in, registro_2_in;
  logic [4:0]  reg_dest_in;
  logic [10:0] jump_dest_addr_in;
  logic        zero_signal_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;

  logic [31:0] a_rd, a_alu, b_rd, b_alu, s_rd, s_alu;
  logic [4:0]  a_dst, b_dst, s_dst;
  logic [10:0] a_tgt, b_tgt, s_tgt;
  logic        a_m2r, a_rw, a_pc, a_stall, a_err;
  logic        b_m2r, b_rw, b_pc, b_stall, b_err;
  logic        s_m2r, s_rw, s_pc, s_stall, s_err;

  logic        act_b = 1'b0;
  int          lat = 2;
  int          n_pass = 0;
  int          n_total = 0;
  logic        m_err = 1'b0;
  logic [31:0] mm [int];
  int          wlist [$];
  exp_t        sbq [$];
  exp_t        pend;
  logic        pend_vld = 1'b0;
  logic        drain_expired = 1'b0;

  always #5 clock = ~clock;

  mem_access #(.DATA_WIDTH(32), .ADDR_BITS(8), .MEM_LATENCY(2)) dut_a (
    .clock(clock), .reset(reset), .result_in(result_in), .registro_2_in(registro_2_in),
    .reg_dest_in(reg_dest_in), .jump_dest_addr_in(jump_dest_addr_in),
    .zero_signal_in(zero_signal_in), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
    .read_data_out(a_rd), .alu_result_out(a_alu), .reg_dest_out(a_dst),
    .MemToReg_out(a_m2r), .RegWrite_out(a_rw), .pc_src_out(a_pc),
    .branch_target_out(a_tgt), .stall_out(a_stall), .addr_error_out(a_err));

  mem_access #(.DATA_WIDTH(32), .ADDR_BITS(8), .MEM_LATENCY(4)) dut_b (
    .clock(clock), .reset(reset), .result_in(result_in), .registro_2_in(registro_2_in),
    .reg_dest_in(reg_dest_in), .jump_dest_addr_in(jump_dest_addr_in),
    .zero_signal_in(zero_signal_in), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
    .read_data_out(b_rd), .alu_result_out(b_alu), .reg_dest_out(b_dst),
    .MemToReg_out(b_m2r), .RegWrite_out(b_rw), .pc_src_out(b_pc),
    .branch_target_out(b_tgt), .stall_out(b_stall), .addr_error_out(b_err));

  assign s_rd    = act_b ? b_rd    : a_rd;
  assign s_alu   = act_b ? b_alu   : a_alu;
  assign s_dst   = act_b ? b_dst   : a_dst;
  assign s_tgt   = act_b ? b_tgt   : a_tgt;
  assign s_m2r   = act_b ? b_m2r   : a_m2r;
  assign s_rw    = act_b ? b_rw    : a_rw;
  assign s_pc    = act_b ? b_pc    : a_pc;
  assign s_stall = act_b ? b_stall : a_stall;
  assign s_err   = act_b ? b_err   : a_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s (lat %0d): got 0x%0h, expected 0x%0h", nm, lat, got, want);
    else
      n_pass++;
  endtask

  // Monitor: each negedge checks last cycle's MEM/WB expectation, then this cycle's comb outputs.
  always @(negedge clock) begin
    if (drain_expired) begin
      n_total++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", sbq.size());
    end
    if (pend_vld) begin
      chk("reg_write", 32'(s_rw), 32'(pend.rw));
      chk("addr_error", 32'(s_err), 32'(pend.err));
      if (pend.kind != K_ILL) chk("mem_to_reg", 32'(s_m2r), 32'(pend.m2r));
      if (pend.kind == K_FULL) begin
        chk("read_data", s_rd, pend.rd);
        chk("alu_result", s_alu, pend.alu);
        chk("reg_dest", 32'(s_dst), 32'(pend.dst));
      end
      pend_vld = 1'b0;
    end
    if (sbq.size() > 0) begin
      pend = sbq.pop_front();
      chk("stall", 32'(s_stall), 32'(pend.stall));
      chk("pc_src", 32'(s_pc), 32'(pend.pc));
      chk("branch_target", 32'(s_tgt), 32'(pend.tgt));
      pend_vld = 1'b1;
    end
  end

  function automatic exp_t mk(input logic stall, input int kind, input logic [31:0] rd);
    exp_t e;
    e.stall = stall;
    e.pc    = Branch_in & zero_signal_in;
    e.tgt   = jump_dest_addr_in;
    e.kind  = kind;
    e.rd    = rd;
    e.alu   = result_in;
    e.dst   = reg_dest_in;
    e.m2r   = (kind == K_BUB) ? 1'b0 : MemToReg_in;
    e.rw    = (kind == K_FULL) ? RegWrite_in : 1'b0;
    e.err   = m_err;
    return e;
  endfunction

  function automatic exp_t zero_rec();
    exp_t e;
    e = '{stall: 1'b0, pc: Branch_in & zero_signal_in, tgt: jump_dest_addr_in, kind: K_FULL,
          rd: 32'h0, alu: 32'h0, dst: 5'h0, m2r: 1'b0, rw: 1'b0, err: 1'b0};
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] dst, input logic m2r,
                        input logic rw, input logic br, input logic z, input logic [10:0] tgt);
    MemRead_in = rd; MemWrite_in = wr; result_in = addr; registro_2_in = data;
    reg_dest_in = dst; MemToReg_in = m2r; RegWrite_in = rw; Branch_in = br;
    zero_signal_in = z; jump_dest_addr_in = tgt;
  endtask

  // Reference: legal loads occupy lat cycles (lat-1 stalled bubbles), all else one cycle.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] dst, input logic m2r,
                       input logic rw, input logic br, input logic z, input logic [10:0] tgt);
    int  idx;
    logic bad;
    set_in(rd, wr, addr, data, dst, m2r, rw, br, z, tgt);
    idx = int'((addr / 4) % 256);
    bad = ((addr % 4 != 0) && (rd || wr)) || (rd && wr);
    if (bad) begin
      m_err = 1'b1;
      sbq.push_back(mk(1'b0, K_ILL, 32'h0));
      step();
    end else if (wr) begin
      mm[idx] = data;
      wlist.push_back(idx);
      sbq.push_back(mk(1'b0, K_FULL, 32'h0));
      step();
    end else if (rd) begin
      for (int i = 0; i < lat - 1; i++) begin
        sbq.push_back(mk(1'b1, K_BUB, 32'h0));
        step();
      end
      sbq.push_back(mk(1'b0, K_FULL, mm[idx]));
      step();
    end else begin
      sbq.push_back(mk(1'b0, K_FULL, 32'h0));
      step();
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    Branch_in = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      sbq.push_back(zero_rec());
      step();
    end
    reset = 1'b0;
  endtask

  task automatic load_then_reset(input logic [31:0] addr);
    set_in(1'b1, 1'b0, addr, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 11'h11);
    sbq.push_back(mk(1'b1, K_BUB, 32'h0));
    step();
    do_reset(1);
  endtask

  task automatic random_instr();
    int          k;
    int          idx;
    logic [31:0] upper;
    logic [31:0] addr;
    k     = $urandom_range(0, 9);
    upper = $urandom & 32'hFFFF_FC00;
    idx   = $urandom_range(0, 255);
    addr  = upper | (32'(idx) << 2);
    if (k >= 6 && wlist.size() > 0) begin
      addr = upper | (32'(wlist[$urandom_range(0, wlist.size() - 1)]) << 2);
      issue(1'b1, 1'b0, addr, $urandom, 5'($urandom), 1'b1, 1'($urandom), 1'($urandom),
            1'($urandom), 11'($urandom));
    end else if (k >= 3 && k <= 5) begin
      issue(1'b0, 1'b1, addr, $urandom, 5'($urandom), 1'b0, 1'b0, 1'($urandom),
            1'($urandom), 11'($urandom));
    end else if (k == 9) begin
      if ($urandom_range(0, 1) == 1)
        issue(1'b1, 1'b1, addr, $urandom, 5'($urandom), 1'b1, 1'b1, 1'($urandom),
              1'($urandom), 11'($urandom));
      else
        issue(1'($urandom), 1'b1, addr | 32'($urandom_range(1, 3)), $urandom, 5'($urandom),
              1'b0, 1'b1, 1'($urandom), 1'($urandom), 11'($urandom));
    end else begin
      issue(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 1'($urandom), 1'($urandom),
            1'($urandom), 11'($urandom));
    end
  endtask

  task automatic run_phase(input logic use_b, input int latency);
    act_b = use_b;
    lat   = latency;
    wlist.delete();
    mm.delete();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    do_reset(2);
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    issue(1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h2A);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h2A);
    if (latency >= 3) load_then_reset(32'h10);
    issue(1'b0, 1'b1, 32'h13, 32'h5555AAAA, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    issue(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    issue(1'b1, 1'b1, 32'h20, 32'h77777777, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    do_reset(1);
    for (int i = 0; i < 80; i++) random_instr();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    for (int i = 0; i < 20 && (sbq.size() > 0 || pend_vld); i++) step();
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    step();
    run_phase(1'b0, 2);
    run_phase(1'b1, 4);
    if (sbq.size() > 0 || pend_vld) begin
      drain_expired = 1'b1;
      step();
      drain_expired = 1'b0;
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
